// File: rtl/iob_shift_reg_sched.sv
// -----------------------------------------------------------------------------
// iob_shift_reg_sched
//
// Time-shares one external dual-port RAM among CH delay-line channels. Each
// cycle a round-robin arbiter grants one requesting channel. The granted
// channel's sample is written at {ch, wptr}, and the sample pushed N-1 pushes
// earlier on that channel is read from {ch, wptr+1 mod N}. Read data returns
// one cycle later and is masked to zero until the channel has wrapped once.
//
// Ports
//   clk_i, cke_i       clock and clock enable (cke_i low freezes all state)
//   arst_i             asynchronous active-high reset
//   rst_i              synchronous clear of all channels (wins over requests)
//   req_i / data_i     per-channel push request and packed samples
//   grant_o            combinational one-hot grant
//   valid_o, ch_o      registered: delayed sample valid and its channel
//   data_o             delayed sample (masked read data)
//   ext_mem_*          external synchronous dual-port RAM interface
// -----------------------------------------------------------------------------
module iob_shift_reg_sched #(
   parameter int DATA_W = 21,
   parameter int N      = 21,
   parameter int CH     = 4,
   parameter int PTR_W  = $clog2(N),
   parameter int CH_W   = $clog2(CH),
   parameter int ADDR_W = CH_W + PTR_W
) (
   input  logic                 clk_i,
   input  logic                 cke_i,
   input  logic                 arst_i,
   input  logic                 rst_i,
   input  logic [CH-1:0]        req_i,
   input  logic [CH*DATA_W-1:0] data_i,
   output logic [CH-1:0]        grant_o,
   output logic                 valid_o,
   output logic [CH_W-1:0]      ch_o,
   output logic [DATA_W-1:0]    data_o,
   output logic                 ext_mem_clk_o,
   output logic                 ext_mem_w_en_o,
   output logic [ADDR_W-1:0]    ext_mem_w_addr_o,
   output logic [DATA_W-1:0]    ext_mem_w_data_o,
   output logic                 ext_mem_r_en_o,
   output logic [ADDR_W-1:0]    ext_mem_r_addr_o,
   input  logic [DATA_W-1:0]    ext_mem_r_data_i
);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
   localparam logic [CH-1:0]    ONE_HOT0 = {{(CH-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0] wptr [CH];
   logic [CH-1:0]    filled;
   logic [CH_W-1:0]  rr;

   logic [CH_W-1:0]  cand;
   logic             found;
   logic [CH_W-1:0]  gnt_idx;
   logic             gnt_vld;
   logic [PTR_W-1:0] cur_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             at_last;

   // Rotating-priority search starting at rr.
   // NOTE: every variable written in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      found   = 1'b0;
      gnt_idx = rr;
      cand    = rr;
      for (int i = 0; i < CH; i++) begin
         cand = CH_W'((int'(rr) + i) % CH);
         if (!found && req_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // A grant is only real when the block is running and not being cleared.
   assign gnt_vld = found && cke_i && !rst_i && !arst_i;

   assign cur_ptr = wptr[gnt_idx];
   assign at_last = (cur_ptr == PTR_LAST);
   // Read slot is the oldest entry: the one this channel overwrites next.
   assign rd_ptr  = at_last ? '0 : cur_ptr + PTR_W'(1);

   assign grant_o = gnt_vld ? (ONE_HOT0 << gnt_idx) : '0;

   assign ext_mem_clk_o    = clk_i;
   assign ext_mem_w_en_o   = gnt_vld;
   assign ext_mem_r_en_o   = gnt_vld;
   assign ext_mem_w_addr_o = {gnt_idx, cur_ptr};
   assign ext_mem_r_addr_o = {gnt_idx, rd_ptr};
   assign ext_mem_w_data_o = data_i[gnt_idx*DATA_W +: DATA_W];

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values. The pointer array is a handful of flops and is reset;
   // the RAM contents are never cleared -- stale data is hidden by filled.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int c = 0; c < CH; c++) wptr[c] <= '0;
         filled  <= '0;
         rr      <= '0;
         valid_o <= 1'b0;
         ch_o    <= '0;
      end else if (cke_i) begin
         if (rst_i) begin
            for (int c = 0; c < CH; c++) wptr[c] <= '0;
            filled  <= '0;
            rr      <= '0;
            valid_o <= 1'b0;
            ch_o    <= '0;
         end else begin
            valid_o <= gnt_vld;
            if (gnt_vld) begin
               wptr[gnt_idx] <= rd_ptr;
               if (at_last) filled[gnt_idx] <= 1'b1;
               rr   <= (gnt_idx == CH_LAST) ? '0 : gnt_idx + CH_W'(1);
               ch_o <= gnt_idx;
            end
         end
      end
   end

   // filled was updated on the same edge as valid_o, so the wrapping push
   // (the one that set filled) is already unmasked.
   assign data_o = (valid_o && filled[ch_o]) ? ext_mem_r_data_i : '0;

endmodule

// File: tb/tb_iob_shift_reg_sched.sv
// -----------------------------------------------------------------------------
// tb_iob_shift_reg_sched
//
// Self-checking bench for iob_shift_reg_sched. A behavioural RAM stands in for
// the memory macro; the reference model keeps per-channel push histories in
// queues and derives each expected output directly as "the sample pushed N-1
// pushes ago on this channel, or zero".
// -----------------------------------------------------------------------------
module tb_iob_shift_reg_sched;

   localparam int DATA_W = 21;
   localparam int N      = 21;
   localparam int CH     = 4;
   localparam int PTR_W  = $clog2(N);
   localparam int CH_W   = $clog2(CH);
   localparam int ADDR_W = CH_W + PTR_W;

   typedef struct packed {
      logic [CH-1:0]     grant;
      logic [1:0]        en;     // {w_en, r_en}
      logic              valid;
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] data;
   } obs_t;

   logic                 clk = 1'b0;
   logic                 cke_i;
   logic                 arst_i;
   logic                 rst_i;
   logic [CH-1:0]        req_i;
   logic [CH*DATA_W-1:0] data_i;
   logic [CH-1:0]        grant_o;
   logic                 valid_o;
   logic [CH_W-1:0]      ch_o;
   logic [DATA_W-1:0]    data_o;
   logic                 ext_mem_clk_o;
   logic                 ext_mem_w_en_o;
   logic [ADDR_W-1:0]    ext_mem_w_addr_o;
   logic [DATA_W-1:0]    ext_mem_w_data_o;
   logic                 ext_mem_r_en_o;
   logic [ADDR_W-1:0]    ext_mem_r_addr_o;
   logic [DATA_W-1:0]    ext_mem_r_data_i;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   iob_shift_reg_sched #(
      .DATA_W(DATA_W), .N(N), .CH(CH)
   ) dut (
      .clk_i            (clk),
      .cke_i            (cke_i),
      .arst_i           (arst_i),
      .rst_i            (rst_i),
      .req_i            (req_i),
      .data_i           (data_i),
      .grant_o          (grant_o),
      .valid_o          (valid_o),
      .ch_o             (ch_o),
      .data_o           (data_o),
      .ext_mem_clk_o    (ext_mem_clk_o),
      .ext_mem_w_en_o   (ext_mem_w_en_o),
      .ext_mem_w_addr_o (ext_mem_w_addr_o),
      .ext_mem_w_data_o (ext_mem_w_data_o),
      .ext_mem_r_en_o   (ext_mem_r_en_o),
      .ext_mem_r_addr_o (ext_mem_r_addr_o),
      .ext_mem_r_data_i (ext_mem_r_data_i)
   );

   // Synchronous-read dual-port RAM; read data holds while r_en is low.
   logic [DATA_W-1:0] ram [2**ADDR_W];
   always @(posedge ext_mem_clk_o) begin
      if (ext_mem_w_en_o) ram[ext_mem_w_addr_o] <= ext_mem_w_data_o;
      if (ext_mem_r_en_o) ext_mem_r_data_i <= ram[ext_mem_r_addr_o];
   end

   // ---------------- reference model ----------------
   int                m_rr;
   logic              m_valid;
   int                m_ch;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] hist [CH][$];

   task automatic model_reset();
      m_rr    = 0;
      m_valid = 1'b0;
      m_ch    = 0;
      m_data  = '0;
      for (int c = 0; c < CH; c++) hist[c].delete();
   endtask

   function automatic string fmt(obs_t o);
      return $sformatf("g=%b en=%b v=%b ch=%0d d=%h", o.grant, o.en, o.valid, o.ch, o.data);
   endfunction

   // One clock: drive at negedge, sample the grant before the edge and the
   // registered outputs #1 after it. Returns DUT observation and model value.
   task automatic do_cycle(input logic [CH-1:0] req, input logic [CH*DATA_W-1:0] din,
                           input logic rst, input logic cke,
                           output obs_t obs, output obs_t exp);
      int g;
      int k;
      int c;
      @(negedge clk);
      req_i  = req;
      data_i = din;
      rst_i  = rst;
      cke_i  = cke;
      #1;
      obs.grant = grant_o;
      obs.en    = {ext_mem_w_en_o, ext_mem_r_en_o};
      g = -1;
      if (cke && !rst) begin
         for (int i = 0; i < CH; i++) begin
            c = (m_rr + i) % CH;
            if (g < 0 && req[c[CH_W-1:0]]) g = c;
         end
      end
      exp.grant = '0;
      exp.en    = 2'b00;
      if (g >= 0) begin
         exp.grant[g[CH_W-1:0]] = 1'b1;
         exp.en = 2'b11;
      end
      if (cke) begin
         if (rst) begin
            model_reset();
         end else if (g >= 0) begin
            k = hist[g].size();
            m_data = (k >= N - 1) ? hist[g][k-(N-1)] : '0;
            hist[g].push_back(din[g*DATA_W +: DATA_W]);
            m_valid = 1'b1;
            m_ch    = g;
            m_rr    = (g + 1) % CH;
         end else begin
            m_valid = 1'b0;
            m_data  = '0;
         end
      end
      @(posedge clk);
      #1;
      obs.valid = valid_o;
      obs.ch    = ch_o;
      obs.data  = data_o;
      exp.valid = m_valid;
      exp.ch    = m_ch[CH_W-1:0];
      exp.data  = m_data;
   endtask

   function automatic logic [CH*DATA_W-1:0] rand_din();
      logic [CH*DATA_W-1:0] d;
      d = '0;
      for (int c = 0; c < CH; c++) d[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      return d;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      obs_t o;
      arst_i = 1'b1;
      rst_i  = 1'b0;
      cke_i  = 1'b1;
      req_i  = '1;
      data_i = rand_din();
      model_reset();
      #3;
      o = {grant_o, ext_mem_w_en_o, ext_mem_r_en_o, valid_o, ch_o, data_o};
      n_checks++;
      if (o !== '0) $display("FAIL reset_state: got %s want all zero", fmt(o));
      else n_pass++;
      @(negedge clk);
      arst_i = 1'b0;
      req_i  = '0;
   endtask

   task automatic test_single_channel();
      obs_t o, e;
      logic [CH*DATA_W-1:0] d;
      for (int k = 0; k < 40; k++) begin
         d = '0;
         d[0 +: DATA_W] = DATA_W'(k + 1);
         do_cycle(4'b0001, d, 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL single k=%0d: got %s want %s", k, fmt(o), fmt(e));
         else n_pass++;
         if (k == 19 || k == 20 || k == 21) begin
            n_checks++;
            if (o.data !== ((k == 19) ? DATA_W'(0) : DATA_W'(k - 19)) || o.valid !== 1'b1)
               $display("FAIL single_boundary k=%0d: got v=%b d=%0d want v=1 d=%0d",
                        k, o.valid, o.data, (k == 19) ? 0 : k - 19);
            else n_pass++;
         end
      end
   endtask

   task automatic test_all_channels();
      obs_t o, e;
      logic [CH-1:0] oh;
      do_cycle('1, rand_din(), 1'b1, 1'b1, o, e);
      n_checks++;
      if (o !== e) $display("FAIL all_clear: got %s want %s", fmt(o), fmt(e));
      else n_pass++;
      for (int i = 0; i < 30 * CH; i++) begin
         do_cycle('1, rand_din(), 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL all i=%0d: got %s want %s", i, fmt(o), fmt(e));
         else n_pass++;
         oh = 1;
         oh = oh << (i % CH);
         n_checks++;
         if (o.grant !== oh) $display("FAIL all_rotation i=%0d: got %b want %b", i, o.grant, oh);
         else n_pass++;
      end
   endtask

   task automatic test_rr_skip();
      obs_t o, e;
      logic [CH-1:0] reqs [5] = '{4'b0000, 4'b0010, 4'b1010, 4'b1010, 4'b1111};
      logic [CH-1:0] want [5] = '{4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b0100};
      for (int i = 0; i < 5; i++) begin
         do_cycle(reqs[i], rand_din(), (i == 0), 1'b1, o, e);
         n_checks++;
         if (o !== e || o.grant !== want[i])
            $display("FAIL rr_skip i=%0d: got %s want %s (grant %b)", i, fmt(o), fmt(e), want[i]);
         else n_pass++;
      end
      for (int i = 0; i < 3 * N * CH; i++) begin
         do_cycle(4'($urandom), rand_din(), 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL rr_follow i=%0d: got %s want %s", i, fmt(o), fmt(e));
         else n_pass++;
      end
   endtask

   task automatic test_rst_clear();
      obs_t o, e;
      logic [CH*DATA_W-1:0] d;
      do_cycle('0, '0, 1'b1, 1'b1, o, e);
      for (int k = 0; k < 30; k++) begin
         d = '0;
         d[0 +: DATA_W] = DATA_W'(100 + k);
         do_cycle(4'b0001, d, 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL clr_pre k=%0d: got %s want %s", k, fmt(o), fmt(e));
         else n_pass++;
      end
      do_cycle(4'b0001, rand_din(), 1'b1, 1'b1, o, e);
      n_checks++;
      if (o.grant !== '0 || o.en !== 2'b00 || o.valid !== 1'b0 || o.data !== '0)
         $display("FAIL clr_pulse: got %s want g=0 en=0 v=0 d=0", fmt(o));
      else n_pass++;
      for (int k = 0; k < 25; k++) begin
         d = '0;
         d[0 +: DATA_W] = DATA_W'(500 + k);
         do_cycle(4'b0001, d, 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL clr_post k=%0d: got %s want %s", k, fmt(o), fmt(e));
         else n_pass++;
         if (k == 19 || k == 20) begin
            n_checks++;
            if (o.data !== ((k == 19) ? DATA_W'(0) : DATA_W'(500)))
               $display("FAIL clr_first k=%0d: got d=%0d want d=%0d", k, o.data, (k == 19) ? 0 : 500);
            else n_pass++;
         end
      end
   endtask

   task automatic test_cke_stall();
      obs_t o, e;
      for (int i = 0; i < 50; i++) begin
         do_cycle('1, rand_din(), 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL stall_pre i=%0d: got %s want %s", i, fmt(o), fmt(e));
         else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
         do_cycle(4'($urandom), rand_din(), 1'($urandom), 1'b0, o, e);
         n_checks++;
         if (o !== e || o.grant !== '0 || o.en !== 2'b00)
            $display("FAIL stall i=%0d: got %s want %s", i, fmt(o), fmt(e));
         else n_pass++;
      end
      for (int i = 0; i < 40; i++) begin
         do_cycle('1, rand_din(), 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL stall_post i=%0d: got %s want %s", i, fmt(o), fmt(e));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      obs_t o, e;
      for (int i = 0; i < 400; i++) begin
         do_cycle(4'($urandom), rand_din(), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 9) != 0), o, e);
         n_checks++;
         if (o !== e) $display("FAIL random i=%0d: got %s want %s", i, fmt(o), fmt(e));
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      obs_t o, e;
      logic [CH*DATA_W-1:0] d;
      for (int i = 0; i < 30; i++) do_cycle('1, rand_din(), 1'b0, 1'b1, o, e);
      // Mid-cycle assertion with requests still high.
      #2;
      arst_i = 1'b1;
      #1;
      o = {grant_o, ext_mem_w_en_o, ext_mem_r_en_o, valid_o, ch_o, data_o};
      n_checks++;
      if (o !== '0) $display("FAIL arst_mid: got %s want all zero", fmt(o));
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      req_i  = '0;
      arst_i = 1'b0;
      model_reset();
      for (int k = 0; k < 25; k++) begin
         d = '0;
         d[0 +: DATA_W] = DATA_W'(900 + k);
         do_cycle(4'b0001, d, 1'b0, 1'b1, o, e);
         n_checks++;
         if (o !== e) $display("FAIL arst_after k=%0d: got %s want %s", k, fmt(o), fmt(e));
         else n_pass++;
         if (k == 20) begin
            n_checks++;
            if (o.data !== DATA_W'(900)) $display("FAIL arst_first: got d=%0d want d=900", o.data);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_all_channels();
      test_rr_skip();
      test_rst_clear();
      test_cke_stall();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/iob_shift_reg_sched.md
# iob_shift_reg_sched

Multi-channel delay-line scheduler that time-shares one external dual-port RAM among CH independent shift-register channels. Each cycle, a round-robin arbiter picks one requesting channel. The block writes that channel's sample and reads back the sample pushed N-1 pushes earlier on the same channel. It sits between several streaming producers and a single memory macro, replacing CH separate shift-register instances.

## Interface
- DATA_W, 21: sample width
- N, 21: delay depth per channel (N >= 2)
- CH, 4: number of channels (CH >= 2)
- PTR_W, $clog2(N): per-channel pointer width
- CH_W, $clog2(CH): channel index width
- ADDR_W, CH_W+PTR_W: memory address width; address = {channel, pointer}
- clk_i  in  1  clock; the only clock
- cke_i  in  1  clock enable; low freezes all state
- arst_i  in  1  reset, asynchronous, active-high
- rst_i  in  1  synchronous clear of all channels
- req_i  in  CH  per-channel push request
- data_i  in  CH*DATA_W  channel c sample at bits [c*DATA_W +: DATA_W]
- grant_o  out  CH  one-hot grant, combinational, same cycle as req_i
- valid_o  out  1  registered; delayed sample available
- ch_o  out  CH_W  registered; channel of the data_o sample
- data_o  out  DATA_W  delayed sample
- ext_mem_clk_o  out  1  equals clk_i
- ext_mem_w_en_o, ext_mem_w_addr_o (ADDR_W), ext_mem_w_data_o (DATA_W)  out  write port
- ext_mem_r_en_o, ext_mem_r_addr_o (ADDR_W)  out  read port
- ext_mem_r_data_i  in  DATA_W  synchronous-read data, valid one cycle after r_en

## Operation
- State:
  - wptr[c] (PTR_W) per channel
  - filled[c] per channel
  - rr pointer (CH_W)
  - valid_o, ch_o registers
- Arbiter:
  - Priority starts at channel rr and moves upward modulo CH.
  - The first channel with req_i set is granted.
  - grant_o = 0 if no request, if rst_i = 1, or if cke_i = 0.
- On a grant to channel g (cke_i = 1):
  - w_en = r_en = 1
  - w_addr = {g, wptr[g]}, w_data = data_i slice g
  - r_addr = {g, rd}, where rd = 0 if wptr[g] == N-1, else wptr[g]+1
  - wptr[g] advances to rd.
  - If wptr[g] == N-1, filled[g] is set next cycle.
  - rr becomes (g+1) mod CH.
- No grant: memory enables are 0, all pointers hold, rr holds.
- Read and write in the same cycle always target different addresses (N >= 2), so the RAM read-during-write mode is irrelevant.
- Output sample for push k (0-based since reset/clear) on channel c:
  - data of push k-(N-1) on channel c when k >= N-1
  - 0 otherwise
- data_o = ext_mem_r_data_i masked by (valid_o & filled[ch_o]), using the updated filled value so that push N-1 is already unmasked.
- Addresses {c, p} with p >= N are never accessed.
- rst_i = 1 (with cke_i = 1):
  - clears wptr, filled, rr, valid_o and ch_o
  - suppresses grants and memory enables
  - rst_i wins over simultaneous requests.
- cke_i = 0: all registers hold, grant_o = 0, memory enables = 0.

## Timing
- arst_i values:
  - wptr = 0, filled = 0, rr = 0, valid_o = 0, ch_o = 0, data_o = 0
  - grant_o = 0, memory enables = 0
- Grant is combinational from req_i in cycle t.
- valid_o, ch_o and data_o appear in cycle t+1; latency 1.
- Throughput: one push per cycle in total across all channels. A request that is not granted is not queued by this block; the producer keeps req_i high until granted.
- Fairness: with all channels requesting continuously, each channel is granted exactly once every CH cycles.
- Wrap-around:
  - The push with wptr == N-1 writes address N-1 and reads address 0.
  - That push's output is unmasked.

## Test plan
- Only channel 0 requests continuously, N=21, data = 1,2,3…:
  - pushes 0..19 output 0
  - push 20 outputs 1, push 21 outputs 2
  - valid_o high from cycle 1.
- All CH=4 channels request every cycle:
  - grants rotate 0,1,2,3,0…
  - each channel's output matches its own sequence delayed by 20 pushes
  - no cross-channel corruption.
- Channels 1 and 3 request, rr = 2:
  - first grant to 3, then 1
  - rr afterwards is 2
  - channels 0 and 2 pointers unchanged.
- rst_i pulsed at push 30 on channel 0 while req_i is high:
  - no grant or memory write that cycle
  - valid_o = 0 the next cycle
  - the next 20 outputs are 0, then the first post-clear sample appears.
- cke_i low for 5 cycles mid-stream:
  - grant_o = 0, enables = 0, outputs held
  - the sequence resumes unchanged.
- arst_i asserted asynchronously mid-cycle:
  - all outputs 0 immediately
  - behaviour after release identical to power-up.
